// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: issues BLOCK_WORDS back-to-back word reads for the
// missing block, steers returned words into the data array, then writes the tag.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  miss_detected,
    input  logic [ADDR_WIDTH-1:0]                 miss_address,
    input  logic                                  memory_data_valid,
    input  logic [15:0]                           memory_data,
    output logic                                  fsm_busy,
    output logic                                  mem_enable,
    output logic [ADDR_WIDTH-1:0]                 memory_address,
    output logic                                  write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0]        word_offset,
    output logic [15:0]                           fill_data,
    output logic                                  write_tag_array
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int CNT_W = OFF_W + 1;
    // Clears the byte-offset bits so base points at the first byte of the block.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(2 * BLOCK_WORDS - 1));

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   base_reg, base_next;
    logic [CNT_W-1:0]        issue_cnt_reg, issue_cnt_next;
    logic [OFF_W-1:0]        recv_cnt_reg, recv_cnt_next;

    logic issuing;
    logic last_word;

    assign issuing   = (state_reg == FILL) && (issue_cnt_reg < CNT_W'(BLOCK_WORDS));
    assign last_word = (recv_cnt_reg == OFF_W'(BLOCK_WORDS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            base_reg      <= '0;
            issue_cnt_reg <= '0;
            recv_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            base_reg      <= base_next;
            issue_cnt_reg <= issue_cnt_next;
            recv_cnt_reg  <= recv_cnt_next;
        end
    end

    // Issue and return counters advance independently; only the return count ends a fill.
    always_comb begin
        state_next     = state_reg;
        base_next      = base_reg;
        issue_cnt_next = issue_cnt_reg;
        recv_cnt_next  = recv_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (miss_detected) begin
                    state_next     = FILL;
                    base_next      = miss_address & ALIGN_MASK;
                    issue_cnt_next = '0;
                    recv_cnt_next  = '0;
                end
            end
            FILL: begin
                if (issuing) begin
                    issue_cnt_next = issue_cnt_reg + CNT_W'(1);
                end
                if (memory_data_valid) begin
                    recv_cnt_next = recv_cnt_reg + OFF_W'(1);
                    if (last_word) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fsm_busy         = 1'b0;
        mem_enable       = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        word_offset      = '0;
        write_tag_array  = 1'b0;
        fill_data        = memory_data;
        if (state_reg == FILL) begin
            fsm_busy       = 1'b1;
            mem_enable     = issuing;
            // Block is aligned, so base + offset never carries out of the block.
            memory_address = issuing ? base_reg + ADDR_WIDTH'({issue_cnt_reg, 1'b0}) : base_reg;
            if (memory_data_valid) begin
                write_data_array = 1'b1;
                word_offset      = recv_cnt_reg;
                write_tag_array  = last_word;
            end
        end
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: fixed 4-cycle memory model, a vector table for
// one fill, and timeline-checked sequences for wrap, back-to-back, reset and strays.
module tb_cache_fill_fsm;

    localparam logic [15:0] KEY = 16'h5A3C;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        fsm_busy;
    logic        mem_enable;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  word_offset;
    logic [15:0] fill_data;
    logic        write_tag_array;

    logic        stray_valid;
    logic [3:0]  pv;
    logic [15:0] pa [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .memory_data_valid(memory_data_valid),
        .memory_data      (memory_data),
        .fsm_busy         (fsm_busy),
        .mem_enable       (mem_enable),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .word_offset      (word_offset),
        .fill_data        (fill_data),
        .write_tag_array  (write_tag_array)
    );

    // Memory: returns addr^KEY exactly 4 cycles after each enabled read; flushed by rst.
    always @(posedge clk) begin
        if (rst) begin
            pv <= 4'b0;
        end else begin
            pv    <= {pv[2:0], mem_enable};
            pa[0] <= memory_address;
            pa[1] <= pa[0];
            pa[2] <= pa[1];
            pa[3] <= pa[2];
        end
    end
    assign memory_data_valid = pv[3] | stray_valid;
    assign memory_data       = pa[3] ^ KEY;

    typedef struct {
        logic        miss;
        logic        busy;
        logic        men;
        logic [15:0] maddr;
        logic        wda;
        logic [2:0]  off;
        logic        wta;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string ctx, input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %h expected %h", ctx, name, act, exp);
        end
    endtask

    task automatic cmp(input string ctx, input logic eb, input logic em, input logic [15:0] ea,
                       input logic ew, input logic [2:0] eo, input logic et,
                       input logic [15:0] ed);
        chk(ctx, "fsm_busy", 16'(fsm_busy), 16'(eb));
        chk(ctx, "mem_enable", 16'(mem_enable), 16'(em));
        chk(ctx, "memory_address", memory_address, ea);
        chk(ctx, "write_data_array", 16'(write_data_array), 16'(ew));
        chk(ctx, "word_offset", 16'(word_offset), 16'(eo));
        chk(ctx, "write_tag_array", 16'(write_tag_array), 16'(et));
        if (ew) chk(ctx, "fill_data", fill_data, ed);
    endtask

    // Walks cycles T+start_k..T+13 of a fill at addr; optional held second miss and reset.
    task automatic run_fill(input logic [15:0] addr, input int start_k, input bit hold,
                            input logic [15:0] next_addr, input int rst_at);
        logic [15:0] base;
        logic        dead, e_busy, e_men, e_wda, e_wta;
        logic [15:0] e_addr;
        logic [2:0]  e_off;
        int          nd, nt;
        base = addr & 16'hFFF0;
        nd = 0;
        nt = 0;
        for (int k = start_k; k <= 13; k++) begin
            @(negedge clk);
            miss_detected = (k == 0) || (hold && k >= 2);
            miss_address  = (hold && k >= 2) ? next_addr : addr;
            rst           = (k == rst_at);
            #1;
            dead   = (rst_at >= 0) && (k > rst_at);
            e_busy = !dead && k >= 1 && k <= 12;
            e_men  = !dead && k >= 1 && k <= 8;
            e_addr = e_men ? base + 16'(2 * (k - 1)) : (e_busy ? base : 16'h0000);
            e_wda  = !dead && k >= 5 && k <= 12;
            e_off  = e_wda ? 3'(k - 5) : 3'd0;
            e_wta  = !dead && k == 12;
            cmp($sformatf("fill %h T+%0d", addr, k), e_busy, e_men, e_addr, e_wda, e_off, e_wta,
                (base + 16'(2 * e_off)) ^ KEY);
            nd += int'(write_data_array);
            nt += int'(write_tag_array);
        end
        if (rst_at < 0) begin
            chk($sformatf("fill %h", addr), "data_write_count", 16'(nd), 16'd8);
            chk($sformatf("fill %h", addr), "tag_write_count", 16'(nt), 16'd1);
        end
        $display("fill addr=%h base=%h data_writes=%0d tag_writes=%0d rst_at=%0d",
                 addr, base, nd, nt, rst_at);
    endtask

    initial begin
        int nd, nt;
        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = 16'h0000;
        stray_valid   = 1'b0;

        //        miss  busy  men   maddr     wda   off   wta
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'h1232, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 16'h1238, 1'b1, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 16'h123A, 1'b1, 3'd1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'h123C, 1'b1, 3'd2, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 16'h123E, 1'b1, 3'd3, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h1230, 1'b1, 3'd4, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 16'h1230, 1'b1, 3'd5, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 16'h1230, 1'b1, 3'd6, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h1230, 1'b1, 3'd7, 1'b1};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        cmp("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000);
        $display("reset applied");

        @(negedge clk);
        rst = 1'b0;
        #1;
        cmp("post-reset idle", 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000);

        nd = 0;
        nt = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            miss_detected = tbl[i].miss;
            miss_address  = 16'h1234;
            #1;
            cmp($sformatf("table T+%0d", i), tbl[i].busy, tbl[i].men, tbl[i].maddr, tbl[i].wda,
                tbl[i].off, tbl[i].wta, (16'h1230 + 16'(2 * tbl[i].off)) ^ KEY);
            nd += int'(write_data_array);
            nt += int'(write_tag_array);
        end
        chk("table fill", "data_write_count", 16'(nd), 16'd8);
        chk("table fill", "tag_write_count", 16'(nt), 16'd1);
        $display("fill addr=1234 base=1230 data_writes=%0d tag_writes=%0d (table)", nd, nt);

        run_fill(16'hFFFF, 0, 1'b0, 16'h0000, -1);

        run_fill(16'h0100, 0, 1'b1, 16'h0200, -1);
        run_fill(16'h0200, 1, 1'b0, 16'h0000, -1);

        run_fill(16'h0500, 0, 1'b0, 16'h0000, 7);
        run_fill(16'h0040, 0, 1'b0, 16'h0000, -1);

        @(negedge clk);
        rst           = 1'b1;
        miss_detected = 1'b1;
        miss_address  = 16'h2000;
        @(negedge clk);
        rst           = 1'b0;
        miss_detected = 1'b0;
        #1;
        cmp("miss with rst", 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0, 16'h0000);
        $display("miss with rst: busy=%0d", fsm_busy);

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stray_valid = 1'b1;
            #1;
            cmp($sformatf("stray valid %0d", i), 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 1'b0,
                16'h0000);
        end
        @(negedge clk);
        stray_valid = 1'b0;
        $display("stray valid pulses applied in idle");
        run_fill(16'h3456, 0, 1'b0, 16'h0000, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
